branch_resolve_unit: RTL

//  Parametrised, registered branch/jump resolution stage for the RISC-V core; sits after register read.

---
 rtl/branch_resolve_unit.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Registered branch/jump resolution stage that sits after register read.
// It resolves B-type conditions (signed and unsigned), JAL and JALR, computes
// the taken-target and redirect PC, compares the outcome against the
// front-end prediction, and keeps saturating retire statistics.
// It has a one-entry output register with a valid/ready handshake on both sides.
module branch_resolve_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [6:0]       i_in_opcode,
  input  logic [2:0]       i_in_funct3,
  input  logic [XLEN-1:0]  i_in_rs1_data,
  input  logic [XLEN-1:0]  i_in_rs2_data,
  input  logic [XLEN-1:0]  i_in_pc,
  input  logic [XLEN-1:0]  i_in_imm,
  input  logic             i_in_pred_taken,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_taken,
  output logic [XLEN-1:0]  o_out_target,
  output logic [XLEN-1:0]  o_out_redirect_pc,
  output logic             o_out_mispredict,
  output logic             o_out_is_ctrl,
  output logic             o_out_illegal,
  input  logic             i_stats_clear,
  output logic [CNT_W-1:0] o_stat_branches,
  output logic [CNT_W-1:0] o_stat_mispredicts
);

  // Opcodes of the control-transfer instructions handled here.
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // funct3[2:1] picks the base comparison, funct3[0] inverts it.
  localparam logic [1:0] CMP_EQ  = 2'b00;
  localparam logic [1:0] CMP_BAD = 2'b01;
  localparam logic [1:0] CMP_LT  = 2'b10;
  localparam logic [1:0] CMP_LTU = 2'b11;

  localparam int N_STATS = 2;
  localparam int STAT_BR = 0;
  localparam int STAT_MP = 1;

  // ---------------------------------------------------------------------------
  // Output register state
  // ---------------------------------------------------------------------------
  logic            r_out_valid;
  logic            r_out_taken;
  logic [XLEN-1:0] r_out_target;
  logic [XLEN-1:0] r_out_redirect_pc;
  logic            r_out_mispredict;
  logic            r_out_is_ctrl;
  logic            r_out_illegal;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic w_in_ready;
  logic w_fire_in;
  logic w_retire;

  // A flush blocks acceptance outright; otherwise accept when the output
  // register is empty or is being drained this cycle.
  assign w_in_ready = !i_flush && (!r_out_valid || i_out_ready);
  assign w_fire_in  = i_in_valid && w_in_ready;
  // Only a result that really leaves the stage counts toward statistics.
  assign w_retire   = r_out_valid && i_out_ready && !i_flush;

  // ---------------------------------------------------------------------------
  // Operand comparison
  // ---------------------------------------------------------------------------
  logic w_eq;
  logic w_ltu;
  logic w_lts;
  logic w_sign_differs;

  assign w_eq           = (i_in_rs1_data == i_in_rs2_data);
  assign w_ltu          = (i_in_rs1_data < i_in_rs2_data);
  assign w_sign_differs = i_in_rs1_data[XLEN-1] ^ i_in_rs2_data[XLEN-1];
  // With equal signs the unsigned order is also the signed order. With
  // different signs, the negative operand (sign bit set) is the smaller one.
  assign w_lts          = w_sign_differs ? i_in_rs1_data[XLEN-1] : w_ltu;

  // ---------------------------------------------------------------------------
  // Target arithmetic (all modulo 2^XLEN, wrap is silently allowed)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] w_pc_rel_target;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_jalr_target;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_pc_rel_target = i_in_pc + i_in_imm;
  assign w_jalr_sum      = i_in_rs1_data + i_in_imm;
  // JALR clears bit 0 of the computed address.
  assign w_jalr_target   = w_jalr_sum & ~XLEN'(1);
  assign w_pc_plus4      = i_in_pc + XLEN'(4);

  // ---------------------------------------------------------------------------
  // Decode and resolve the incoming operation
  // ---------------------------------------------------------------------------
  logic            w_is_branch;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_cond_base;
  logic            w_cond_illegal;
  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_is_ctrl;
  logic            w_illegal;
  logic            w_mispredict;

  assign w_is_branch = (i_in_opcode == OP_BRANCH);
  assign w_is_jal    = (i_in_opcode == OP_JAL);
  assign w_is_jalr   = (i_in_opcode == OP_JALR);

  // Evaluate the B-type base comparison selected by funct3[2:1].
  always_comb begin
    w_cond_base    = 1'b0;
    w_cond_illegal = 1'b0;
    case (i_in_funct3[2:1])
      CMP_EQ:  w_cond_base = w_eq;
      CMP_LT:  w_cond_base = w_lts;
      CMP_LTU: w_cond_base = w_ltu;
      CMP_BAD: w_cond_illegal = 1'b1;
      default: w_cond_illegal = 1'b1;
    endcase
  end

  // Resolve direction, target and classification for the current operation.
  always_comb begin
    w_taken   = 1'b0;
    w_target  = '0;
    w_is_ctrl = 1'b0;
    w_illegal = 1'b0;
    if (w_is_branch) begin
      w_is_ctrl = 1'b1;
      w_target  = w_pc_rel_target;
      if (w_cond_illegal) begin
        // Reserved funct3 values: never taken, flagged for the trap logic.
        w_illegal = 1'b1;
      end else begin
        w_taken = w_cond_base ^ i_in_funct3[0];
      end
    end else if (w_is_jal) begin
      w_is_ctrl = 1'b1;
      w_taken   = 1'b1;
      w_target  = w_pc_rel_target;
    end else if (w_is_jalr) begin
      w_is_ctrl = 1'b1;
      w_taken   = 1'b1;
      w_target  = w_jalr_target;
    end
  end

  // A non-control op resolves as not-taken, so a taken prediction on it is a
  // mispredict and the redirect falls through to pc+4.
  assign w_redirect_pc = w_taken ? w_target : w_pc_plus4;
  assign w_mispredict  = w_taken ^ i_in_pred_taken;

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // Track occupancy of the output register; a flush empties it and takes
  // priority over both a drain and a new acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_fire_in) begin
      r_out_valid <= 1'b1;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Capture the resolved result on acceptance. The result is held otherwise,
  // so it stays stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_taken       <= 1'b0;
      r_out_target      <= '0;
      r_out_redirect_pc <= '0;
      r_out_mispredict  <= 1'b0;
      r_out_is_ctrl     <= 1'b0;
      r_out_illegal     <= 1'b0;
    end else if (w_fire_in) begin
      r_out_taken       <= w_taken;
      r_out_target      <= w_target;
      r_out_redirect_pc <= w_redirect_pc;
      r_out_mispredict  <= w_mispredict;
      r_out_is_ctrl     <= w_is_ctrl;
      r_out_illegal     <= w_illegal;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating retire statistics
  // ---------------------------------------------------------------------------
  logic [N_STATS-1:0] w_stat_inc;
  logic [CNT_W-1:0]   w_stat_val [N_STATS];

  assign w_stat_inc[STAT_BR] = r_out_is_ctrl;
  assign w_stat_inc[STAT_MP] = r_out_mispredict;

  for (genvar gi = 0; gi < N_STATS; gi++) begin : g_stat
    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = (r_cnt == {CNT_W{1'b1}});

    // Count retiring events up to all-ones; a clear wins over an increment.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (i_stats_clear) begin
        r_cnt <= '0;
      end else if (w_retire && w_stat_inc[gi] && !w_at_max) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_stat_val[gi] = r_cnt;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_in_ready         = w_in_ready;
  assign o_out_valid        = r_out_valid;
  assign o_out_taken        = r_out_taken;
  assign o_out_target       = r_out_target;
  assign o_out_redirect_pc  = r_out_redirect_pc;
  assign o_out_mispredict   = r_out_mispredict;
  assign o_out_is_ctrl      = r_out_is_ctrl;
  assign o_out_illegal      = r_out_illegal;
  assign o_stat_branches    = w_stat_val[STAT_BR];
  assign o_stat_mispredicts = w_stat_val[STAT_MP];

endmodule
